// File: rtl/datapath_alu_pkg.sv
// Shared encodings and widths for the datapath ALU slice: ALU_op codes,
// operand source selects, register widths and immediate extension helpers.
package datapath_alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PAGE_W = 4;
  localparam int unsigned CMP_W  = 3;
  localparam int unsigned INTR_W = 9;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_NOT    = 4'd5,
    OP_SHL    = 4'd6,
    OP_SHR    = 4'd7,
    OP_SRA    = 4'd8,
    OP_PASS_B = 4'd9,
    OP_CMP    = 4'd10,
    OP_PASS_A = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    SRC_A_R    = 3'd0,
    SRC_A_SP   = 3'd1,
    SRC_A_RA   = 3'd2,
    SRC_A_MEM  = 3'd3,
    SRC_A_PC   = 3'd4,
    SRC_A_PAGE = 3'd5,
    SRC_A_INTR = 3'd6,
    SRC_A_ZERO = 3'd7
  } src_a_e;

  typedef enum logic [3:0] {
    SRC_B_R      = 4'd0,
    SRC_B_ZEXT12 = 4'd1,
    SRC_B_ZEXT8  = 4'd2,
    SRC_B_SEXT8  = 4'd3,
    SRC_B_MEM    = 4'd4,
    SRC_B_SEXT12 = 4'd5,
    SRC_B_ONE    = 4'd6,
    SRC_B_TWO    = 4'd7,
    SRC_B_SP     = 4'd8,
    SRC_B_ZERO   = 4'd9
  } src_b_e;

  function automatic word_t zext12(input logic [11:0] v);
    return {4'b0, v};
  endfunction

  function automatic word_t sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  function automatic word_t zext8(input logic [7:0] v);
    return {8'b0, v};
  endfunction

  function automatic word_t sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/datapath_alu_if.sv
// Control/data bundle between decode, the ALU slice and writeback.
// master = decode/writeback side, slave = datapath slice.
interface datapath_alu_if;
  logic        r_write;
  logic        page_write;
  logic        compare_write;
  logic        stack_pointer_write;
  logic        return_address_write;
  logic        interrupt_write;
  logic        r_backup;
  logic        r_restore;
  logic [15:0] r_input;
  logic [3:0]  page_input;
  logic [2:0]  compare_input;
  logic [15:0] stack_pointer_input;
  logic [15:0] return_address_input;
  logic [8:0]  interrupt_input;
  logic [2:0]  ALU_src_A;
  logic [3:0]  ALU_src_B;
  logic [15:0] new_PC;
  logic [15:0] memory_out;
  logic [11:0] zero_12_to_16;
  logic [11:0] sign_12_to_16;
  logic [7:0]  zero_8_to_16;
  logic [7:0]  sign_8_to_16;
  logic        mem_shift;
  logic [3:0]  ALU_op;
  logic [15:0] result;
  logic        zero_indicator;
  logic [2:0]  compare_flags;
  logic        should_skip;

  modport master (
    output r_write, page_write, compare_write, stack_pointer_write,
           return_address_write, interrupt_write, r_backup, r_restore,
           r_input, page_input, compare_input, stack_pointer_input,
           return_address_input, interrupt_input, ALU_src_A, ALU_src_B,
           new_PC, memory_out, zero_12_to_16, sign_12_to_16, zero_8_to_16,
           sign_8_to_16, mem_shift, ALU_op,
    input  result, zero_indicator, compare_flags, should_skip
  );

  modport slave (
    input  r_write, page_write, compare_write, stack_pointer_write,
           return_address_write, interrupt_write, r_backup, r_restore,
           r_input, page_input, compare_input, stack_pointer_input,
           return_address_input, interrupt_input, ALU_src_A, ALU_src_B,
           new_PC, memory_out, zero_12_to_16, sign_12_to_16, zero_8_to_16,
           sign_8_to_16, mem_shift, ALU_op,
    output result, zero_indicator, compare_flags, should_skip
  );
endinterface

// File: rtl/datapath_alu_core.sv
// Combinational ALU: operation select, zero detect and signed compare flags.
module datapath_alu_core
  import datapath_alu_pkg::*;
(
  input  word_t       a,
  input  word_t       b,
  input  alu_op_e     op,
  output word_t       result,
  output logic        zero_indicator,
  output logic [2:0]  compare_flags
);

  logic lt;
  logic eq;

  always_comb begin
    result = a;
    case (op)
      OP_ADD:         result = a + b;
      OP_SUB, OP_CMP: result = a - b;
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      OP_NOT:         result = ~a;
      OP_SHL:         result = a << b[3:0];
      OP_SHR:         result = a >> b[3:0];
      OP_SRA:         result = $unsigned($signed(a) >>> b[3:0]);
      OP_PASS_B:      result = b;
      default:        result = a;
    endcase
  end

  // Flags are independent of op so a compare can ride along with any operation.
  assign lt             = $signed(a) < $signed(b);
  assign eq             = (a == b);
  assign compare_flags  = {lt, eq, ~(lt | eq)};
  assign zero_indicator = (result == '0);

endmodule

// File: rtl/datapath_alu_fragment.sv
// Datapath slice: special registers, operand muxes and ALU core.
// Define DATAPATH_ALU_SHADOW_EN to build the r shadow register (r_backup/r_restore).
module datapath_alu_fragment
  import datapath_alu_pkg::*;
(
  input logic          clk,
  input logic          reset,
  datapath_alu_if.slave bus
);

  word_t             r;
  word_t             sp;
  word_t             ra;
  logic [PAGE_W-1:0] page;
  logic [CMP_W-1:0]  compare_reg;
  logic [INTR_W-1:0] intr;

  word_t       mem_operand;
  word_t       a;
  word_t       b;
  logic [2:0]  flags;

`ifdef DATAPATH_ALU_SHADOW_EN
  word_t shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r      <= '0;
      shadow <= '0;
    end else begin
      if (bus.r_restore)    r <= shadow;
      else if (bus.r_write) r <= bus.r_input;
      if (bus.r_backup)     shadow <= r;
    end
  end
`else
  logic unused_shadow_ctrl;
  assign unused_shadow_ctrl = bus.r_backup ^ bus.r_restore;

  always_ff @(posedge clk) begin
    if (reset)            r <= '0;
    else if (bus.r_write) r <= bus.r_input;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sp          <= '0;
      ra          <= '0;
      page        <= '0;
      compare_reg <= '0;
      intr        <= '0;
    end else begin
      if (bus.stack_pointer_write)  sp          <= bus.stack_pointer_input;
      if (bus.return_address_write) ra          <= bus.return_address_input;
      if (bus.page_write)           page        <= bus.page_input;
      if (bus.compare_write)        compare_reg <= bus.compare_input;
      if (bus.interrupt_write)      intr        <= bus.interrupt_input;
    end
  end

  assign mem_operand = bus.mem_shift ? {bus.memory_out[14:0], 1'b0} : bus.memory_out;

  always_comb begin
    a = '0;
    case (src_a_e'(bus.ALU_src_A))
      SRC_A_R:    a = r;
      SRC_A_SP:   a = sp;
      SRC_A_RA:   a = ra;
      SRC_A_MEM:  a = mem_operand;
      SRC_A_PC:   a = bus.new_PC;
      SRC_A_PAGE: a = {{(DATA_W-PAGE_W){1'b0}}, page};
      SRC_A_INTR: a = {{(DATA_W-INTR_W){1'b0}}, intr};
      default:    a = '0;
    endcase
  end

  always_comb begin
    b = '0;
    case (src_b_e'(bus.ALU_src_B))
      SRC_B_R:      b = r;
      SRC_B_ZEXT12: b = zext12(bus.zero_12_to_16);
      SRC_B_ZEXT8:  b = zext8(bus.zero_8_to_16);
      SRC_B_SEXT8:  b = sext8(bus.sign_8_to_16);
      SRC_B_MEM:    b = mem_operand;
      SRC_B_SEXT12: b = sext12(bus.sign_12_to_16);
      SRC_B_ONE:    b = 16'd1;
      SRC_B_TWO:    b = 16'd2;
      SRC_B_SP:     b = sp;
      default:      b = '0;
    endcase
  end

  datapath_alu_core u_core (
    .a              (a),
    .b              (b),
    .op             (alu_op_e'(bus.ALU_op)),
    .result         (bus.result),
    .zero_indicator (bus.zero_indicator),
    .compare_flags  (flags)
  );

  assign bus.compare_flags = flags;
  assign bus.should_skip   = |(compare_reg & flags);

endmodule

// File: tb/tb_datapath_alu_fragment.sv
// Self-checking bench for datapath_alu_fragment; shadow checks follow
// DATAPATH_ALU_SHADOW_EN the same way the RTL does.
module tb_datapath_alu_fragment;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  datapath_alu_if bus ();

  datapath_alu_fragment dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Architectural state as the bench expects it
  logic [15:0] m_r, m_shadow, m_sp, m_ra;
  logic [3:0]  m_page;
  logic [2:0]  m_cmp;
  logic [8:0]  m_intr;

  function automatic logic [15:0] model_mem();
    logic [15:0] m;
    m = bus.memory_out;
    if (bus.mem_shift) m = m << 1;
    return m;
  endfunction

  function automatic logic [15:0] model_a();
    logic [15:0] opts [8];
    opts = '{m_r, m_sp, m_ra, model_mem(), bus.new_PC,
             {12'b0, m_page}, {7'b0, m_intr}, 16'h0};
    return opts[bus.ALU_src_A];
  endfunction

  function automatic logic [15:0] model_b();
    logic [15:0] opts [16];
    for (int i = 0; i < 16; i++) opts[i] = 16'h0;
    opts[0] = m_r;
    opts[1] = {4'h0, bus.zero_12_to_16};
    opts[2] = {8'h0, bus.zero_8_to_16};
    opts[3] = 16'(int'($signed(bus.sign_8_to_16)));
    opts[4] = model_mem();
    opts[5] = 16'(int'($signed(bus.sign_12_to_16)));
    opts[6] = 16'd1;
    opts[7] = 16'd2;
    opts[8] = m_sp;
    return opts[bus.ALU_src_B];
  endfunction

  function automatic logic [15:0] model_result();
    int ua, ub, sa, n, r;
    logic [15:0] av, bv;
    av = model_a();
    bv = model_b();
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    n  = ub % 16;
    case (int'(bus.ALU_op))
      0:       r = ua + ub;
      1, 10:   r = ua - ub;
      2:       r = ua & ub;
      3:       r = ua | ub;
      4:       r = ua ^ ub;
      5:       r = 65535 - ua;
      6:       r = ua * (1 << n);
      7:       r = ua / (1 << n);
      8:       r = sa >>> n;
      9:       r = ub;
      default: r = ua;
    endcase
    return 16'(r);
  endfunction

  function automatic logic [2:0] model_flags();
    int sa, sb;
    sa = int'($signed(model_a()));
    sb = int'($signed(model_b()));
    if (sa < sb)       return 3'b100;
    else if (sa == sb) return 3'b010;
    else               return 3'b001;
  endfunction

  task automatic tick();
    logic [15:0] n_r, n_shadow, n_sp, n_ra;
    logic [3:0]  n_page;
    logic [2:0]  n_cmp_v;
    logic [8:0]  n_intr;
    n_r = m_r; n_shadow = m_shadow; n_sp = m_sp; n_ra = m_ra;
    n_page = m_page; n_cmp_v = m_cmp; n_intr = m_intr;
    if (reset) begin
      n_r = 0; n_shadow = 0; n_sp = 0; n_ra = 0; n_page = 0; n_cmp_v = 0; n_intr = 0;
    end else begin
`ifdef DATAPATH_ALU_SHADOW_EN
      if (bus.r_restore)    n_r = m_shadow;
      else if (bus.r_write) n_r = bus.r_input;
      if (bus.r_backup)     n_shadow = m_r;
`else
      if (bus.r_write) n_r = bus.r_input;
`endif
      if (bus.stack_pointer_write)  n_sp = bus.stack_pointer_input;
      if (bus.return_address_write) n_ra = bus.return_address_input;
      if (bus.page_write)           n_page = bus.page_input;
      if (bus.compare_write)        n_cmp_v = bus.compare_input;
      if (bus.interrupt_write)      n_intr = bus.interrupt_input;
    end
    @(posedge clk);
    #1;
    m_r = n_r; m_shadow = n_shadow; m_sp = n_sp; m_ra = n_ra;
    m_page = n_page; m_cmp = n_cmp_v; m_intr = n_intr;
  endtask

  task automatic idle_inputs();
    bus.r_write = 0; bus.page_write = 0; bus.compare_write = 0;
    bus.stack_pointer_write = 0; bus.return_address_write = 0; bus.interrupt_write = 0;
    bus.r_backup = 0; bus.r_restore = 0;
    bus.r_input = 0; bus.page_input = 0; bus.compare_input = 0;
    bus.stack_pointer_input = 0; bus.return_address_input = 0; bus.interrupt_input = 0;
    bus.ALU_src_A = 0; bus.ALU_src_B = 0; bus.new_PC = 0; bus.memory_out = 0;
    bus.zero_12_to_16 = 0; bus.sign_12_to_16 = 0; bus.zero_8_to_16 = 0; bus.sign_8_to_16 = 0;
    bus.mem_shift = 0; bus.ALU_op = 0;
  endtask

  task automatic set_enables(input logic v);
    bus.r_write = v; bus.page_write = v; bus.compare_write = v;
    bus.stack_pointer_write = v; bus.return_address_write = v; bus.interrupt_write = v;
    bus.r_backup = v; bus.r_restore = v;
  endtask

  task automatic test_reset();
    idle_inputs();
    set_enables(1'b1);
    bus.r_input = 16'hBEEF; bus.page_input = 4'hA; bus.compare_input = 3'b111;
    bus.stack_pointer_input = 16'h1111; bus.return_address_input = 16'h2222;
    bus.interrupt_input = 9'h1FF;
    reset = 1;
    tick();
    reset = 0;
    #1;
    n_cmp++;
    if (bus.result !== 16'h0) begin n_err++; $display("FAIL reset_result: got %h want 0000", bus.result); end
    n_cmp++;
    if (bus.zero_indicator !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b want 1", bus.zero_indicator); end
    n_cmp++;
    if (bus.compare_flags !== 3'b010) begin n_err++; $display("FAIL reset_flags: got %b want 010", bus.compare_flags); end
    n_cmp++;
    if (bus.should_skip !== 1'b0) begin n_err++; $display("FAIL reset_skip: got %b want 0", bus.should_skip); end
    idle_inputs();
    set_enables(1'b1);
    tick();
    #1;
    n_cmp++;
    if (bus.result !== 16'h0 || bus.zero_indicator !== 1'b1) begin
      n_err++; $display("FAIL reset_load: got %h/%b want 0000/1", bus.result, bus.zero_indicator);
    end
    idle_inputs();
  endtask

  task automatic test_accumulate();
    idle_inputs();
    reset = 1; tick(); reset = 0;
    bus.ALU_src_A = 3'd0; bus.ALU_src_B = 4'd5; bus.sign_12_to_16 = 12'd5;
    bus.r_write = 1; bus.r_input = 16'd5;
    #1;
    n_cmp++;
    if (bus.result !== 16'd5 || bus.zero_indicator !== 1'b0) begin
      n_err++; $display("FAIL accum_first: got %h/%b want 0005/0", bus.result, bus.zero_indicator);
    end
    tick();
    bus.r_write = 0;
    bus.sign_12_to_16 = 12'hFFB;
    #1;
    n_cmp++;
    if (bus.result !== 16'd0 || bus.zero_indicator !== 1'b1) begin
      n_err++; $display("FAIL accum_cancel: got %h/%b want 0000/1", bus.result, bus.zero_indicator);
    end
    idle_inputs();
  endtask

  task automatic test_jump_relative();
    idle_inputs();
    bus.ALU_src_A = 3'd4; bus.new_PC = 16'd6;
    bus.ALU_src_B = 4'd5; bus.sign_12_to_16 = 12'd3; bus.mem_shift = 1;
    #1;
    n_cmp++;
    if (bus.result !== 16'd9 || bus.zero_indicator !== 1'b0) begin
      n_err++; $display("FAIL jump_rel: got %h/%b want 0009/0", bus.result, bus.zero_indicator);
    end
    bus.sign_12_to_16 = 12'hFFA;
    #1;
    n_cmp++;
    if (bus.result !== 16'd0 || bus.zero_indicator !== 1'b1) begin
      n_err++; $display("FAIL jump_rel_neg: got %h/%b want 0000/1", bus.result, bus.zero_indicator);
    end
    idle_inputs();
  endtask

  task automatic test_mem_shift();
    idle_inputs();
    bus.ALU_src_A = 3'd7; bus.ALU_src_B = 4'd4; bus.memory_out = 16'h0003; bus.mem_shift = 1;
    #1;
    n_cmp++;
    if (bus.result !== 16'd6) begin n_err++; $display("FAIL mem_shift_on: got %h want 0006", bus.result); end
    bus.mem_shift = 0;
    #1;
    n_cmp++;
    if (bus.result !== 16'd3) begin n_err++; $display("FAIL mem_shift_off: got %h want 0003", bus.result); end
    bus.memory_out = 16'h8001; bus.mem_shift = 1; bus.ALU_src_A = 3'd3; bus.ALU_src_B = 4'd9; bus.ALU_op = 4'd11;
    #1;
    n_cmp++;
    if (bus.result !== 16'h0002) begin n_err++; $display("FAIL mem_shift_a: got %h want 0002", bus.result); end
    idle_inputs();
  endtask

  task automatic test_skip();
    idle_inputs();
    bus.compare_write = 1; bus.compare_input = 3'b010;
    bus.r_write = 1; bus.r_input = 16'd7;
    tick();
    idle_inputs();
    bus.ALU_src_A = 3'd0; bus.ALU_src_B = 4'd1; bus.zero_12_to_16 = 12'd7;
    #1;
    n_cmp++;
    if (bus.compare_flags !== 3'b010 || bus.should_skip !== 1'b1) begin
      n_err++; $display("FAIL skip_eq: got %b/%b want 010/1", bus.compare_flags, bus.should_skip);
    end
    bus.zero_12_to_16 = 12'd8;
    #1;
    n_cmp++;
    if (bus.compare_flags !== 3'b100 || bus.should_skip !== 1'b0) begin
      n_err++; $display("FAIL skip_lt: got %b/%b want 100/0", bus.compare_flags, bus.should_skip);
    end
    // signed: 7 > -1
    bus.ALU_src_B = 4'd3; bus.sign_8_to_16 = 8'hFF;
    #1;
    n_cmp++;
    if (bus.compare_flags !== 3'b001 || bus.should_skip !== 1'b0) begin
      n_err++; $display("FAIL skip_gt_signed: got %b/%b want 001/0", bus.compare_flags, bus.should_skip);
    end
    idle_inputs();
  endtask

  task automatic test_shadow();
    idle_inputs();
    bus.r_write = 1; bus.r_input = 16'h1234;
    tick();
    idle_inputs();
    bus.r_backup = 1; bus.r_write = 1; bus.r_input = 16'hAAAA;
    tick();
    idle_inputs();
    bus.r_write = 1; bus.r_input = 16'h0000;
    tick();
    idle_inputs();
    bus.ALU_src_B = 4'd9;
    #1;
    n_cmp++;
    if (bus.result !== 16'h0000) begin n_err++; $display("FAIL shadow_cleared: got %h want 0000", bus.result); end
    bus.r_restore = 1;
    tick();
    bus.r_restore = 0;
    #1;
`ifdef DATAPATH_ALU_SHADOW_EN
    n_cmp++;
    if (bus.result !== 16'h1234) begin n_err++; $display("FAIL shadow_restore: got %h want 1234", bus.result); end
    bus.r_restore = 1; bus.r_write = 1; bus.r_input = 16'h5555;
    tick();
    idle_inputs();
    bus.ALU_src_B = 4'd9;
    #1;
    n_cmp++;
    if (bus.result !== 16'h1234) begin n_err++; $display("FAIL shadow_restore_wins: got %h want 1234", bus.result); end
`else
    n_cmp++;
    if (bus.result !== 16'h0000) begin n_err++; $display("FAIL shadow_ignored: got %h want 0000", bus.result); end
    bus.r_restore = 1; bus.r_write = 1; bus.r_input = 16'h5555;
    tick();
    idle_inputs();
    bus.ALU_src_B = 4'd9;
    #1;
    n_cmp++;
    if (bus.result !== 16'h5555) begin n_err++; $display("FAIL shadow_write_wins: got %h want 5555", bus.result); end
`endif
    idle_inputs();
  endtask

  task automatic test_random();
    logic [15:0] exp_r;
    logic [2:0]  exp_f;
    for (int i = 0; i < 300; i++) begin
      bus.r_write = 1'($urandom); bus.page_write = 1'($urandom); bus.compare_write = 1'($urandom);
      bus.stack_pointer_write = 1'($urandom); bus.return_address_write = 1'($urandom);
      bus.interrupt_write = 1'($urandom);
      bus.r_backup = 1'($urandom_range(0, 3) == 0); bus.r_restore = 1'($urandom_range(0, 3) == 0);
      bus.r_input = 16'($urandom); bus.page_input = 4'($urandom); bus.compare_input = 3'($urandom);
      bus.stack_pointer_input = 16'($urandom); bus.return_address_input = 16'($urandom);
      bus.interrupt_input = 9'($urandom);
      reset = 1'($urandom_range(0, 40) == 0);
      tick();
      reset = 0;
      bus.ALU_src_A = 3'($urandom); bus.ALU_src_B = 4'($urandom); bus.ALU_op = 4'($urandom);
      bus.new_PC = 16'($urandom); bus.memory_out = 16'($urandom); bus.mem_shift = 1'($urandom);
      bus.zero_12_to_16 = 12'($urandom); bus.sign_12_to_16 = 12'($urandom);
      bus.zero_8_to_16 = 8'($urandom); bus.sign_8_to_16 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) bus.ALU_src_B = 4'(bus.ALU_src_A);
      #1;
      exp_r = model_result();
      exp_f = model_flags();
      n_cmp++;
      if (bus.result !== exp_r || bus.zero_indicator !== (exp_r == 16'h0) ||
          bus.compare_flags !== exp_f || bus.should_skip !== |(m_cmp & exp_f)) begin
        n_err++;
        $display("FAIL random[%0d] op=%0d a=%0d b=%0d: got %h/%b/%b/%b want %h/%b/%b/%b",
                 i, bus.ALU_op, bus.ALU_src_A, bus.ALU_src_B,
                 bus.result, bus.zero_indicator, bus.compare_flags, bus.should_skip,
                 exp_r, exp_r == 16'h0, exp_f, |(m_cmp & exp_f));
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1;
    m_r = 0; m_shadow = 0; m_sp = 0; m_ra = 0; m_page = 0; m_cmp = 0; m_intr = 0;
    idle_inputs();
    test_reset();
    test_accumulate();
    test_jump_relative();
    test_mem_shift();
    test_skip();
    test_shadow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/datapath_alu_fragment.md
# datapath_alu_fragment

Processor datapath slice that holds the architectural special registers, selects two 16-bit ALU operands from those registers and from the immediate and extend fields, and computes a combinational result. It also produces the zero, compare-flag and skip indicators. It sits between instruction decode/control (write enables, source selects, ALU_op) and the writeback/PC logic, which consumes `result` and `should_skip`.

## Interface
- No parameters.
- `clk` in 1: single clock; all registers update on the rising edge.
- `reset` in 1: synchronous, active-high; clears all registers.
- `r_write`, `page_write`, `compare_write`, `stack_pointer_write`, `return_address_write`, `interrupt_write` in 1 each: load enables for the registers below.
- `r_backup`, `r_restore` in 1: shadow register copy controls.
- `r_input` in 16; `page_input` in 4; `compare_input` in 3; `stack_pointer_input` in 16; `return_address_input` in 16; `interrupt_input` in 9: register load data.
- `ALU_src_A` in 3; `ALU_src_B` in 4: operand selects.
- `new_PC` in 16, `memory_out` in 16: external operands.
- `zero_12_to_16`, `sign_12_to_16` in 12 each: immediates to be zero- and sign-extended to 16 bits.
- `zero_8_to_16`, `sign_8_to_16` in 8 each: immediates to be zero- and sign-extended to 16 bits.
- `mem_shift` in 1: shift the memory operand left by 1.
- `ALU_op` in 4: operation select.
- `result` out 16: ALU result.
- `zero_indicator` out 1: asserted when `result == 0`.
- `compare_flags` out 3: signed comparison of A and B, ordered {lt, eq, gt}.
- `should_skip` out 1: `|(compare_reg & compare_flags)`.

## Operation
- **Registers:** r (16), shadow (16), page (4), compare_reg (3), sp (16), ra (16), intr (9). Each loads its input when its enable is high.
- **Shadow register:**
  - `r_backup` loads shadow ← r, using the old r value.
  - `r_restore` loads r ← shadow.
  - If `r_restore` and `r_write` are both high, restore wins.
- **A source (`ALU_src_A`):** 0 r, 1 sp, 2 ra, 3 memory operand, 4 `new_PC`, 5 page zero-extended, 6 intr zero-extended, 7 zero.
- **B source (`ALU_src_B`):**
  - 0 r; 1 zext12; 2 zext8; 3 sext8; 4 memory operand; 5 sext12.
  - 6 constant 1; 7 constant 2; 8 sp; 9–15 zero.
- **Memory operand:** `memory_out << 1` when `mem_shift` = 1, otherwise `memory_out`. `mem_shift` affects only the memory operand.
- **ALU_op:**
  - 0 add, 1 sub (A−B), 2 and, 3 or, 4 xor, 5 not A.
  - 6 shl A by B[3:0], 7 logical shr, 8 arithmetic shr.
  - 9 pass B, 10 compare (result = A−B).
  - 11–15 pass A.
- **Arithmetic:** modulo 2^16; carry and overflow are discarded.
- **Flags:** `compare_flags` is computed every cycle regardless of op. Exactly one bit is set.

## Timing
- `result`, `zero_indicator`, `compare_flags` and `should_skip` are purely combinational from the register outputs and inputs, with zero latency.
- Register writes take effect at the rising edge. A value written at edge N is visible in `result` right after edge N.
- **Reset values:** all registers and shadow are 0. With selects at 0 and op add, `result` = 0, `zero_indicator` = 1, `compare_flags` = eq (3'b010), `should_skip` = 0.
- `reset` has priority over every enable in the same cycle.

## Configuration
- `DATAPATH_ALU_SHADOW_EN` defined: shadow register present; `r_backup` and `r_restore` behave as specified above.
- `DATAPATH_ALU_SHADOW_EN` undefined: no shadow register is built; `r_backup` and `r_restore` are ignored.

## Structure
- **Package `datapath_alu_pkg`:** ALU_op encodings, A/B select encodings, register widths.
- **Sub-module `datapath_alu_core`:** combinational operation, zero and compare logic.
- **Top level:** registers and operand muxes.

## Test plan
- **Reset load:** reset, then all enables high with zero inputs → `result` = 0, `zero_indicator` = 1.
- **Accumulate:** `r_write` = 1, A = 0, B = 5, sext12 = 5, `r_input` fed from `result`.
  - First edge → `result` = 5, `zero_indicator` = 0.
  - Set sext12 = −5 (0xFFB) and clock → r = 5, `result` = 0, `zero_indicator` = 1.
- **Jump-relative:** A = 4, `new_PC` = 6, B = 5, sext12 = 3, `mem_shift` = 1 → `result` = 9, `zero_indicator` = 0.
- **Memory shift:** B = 4, `memory_out` = 0x0003, `mem_shift` = 1, A = 7 → `result` = 6.
- **Skip:** load compare_reg = 3'b010, then A = r = 7, B = 1 → zext12 = 7 → `compare_flags` = 010, `should_skip` = 1; change zext12 to 8 → flags = 100, `should_skip` = 0.
- **Backup/restore (macro defined):** r = 0x1234, pulse `r_backup`, write r = 0, pulse `r_restore` → r = 0x1234. Assert restore and write together → restore wins.
